// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants, scan-state type and key numbering for the 3x3 keypad scanner.
package keypad_pkg;

   // Active-low row drive patterns, ordered {r3,r2,r1}
   localparam logic [2:0] ROW_PAT0 = 3'b110;
   localparam logic [2:0] ROW_PAT1 = 3'b101;
   localparam logic [2:0] ROW_PAT2 = 3'b011;

   localparam logic [3:0] KEY_NONE = 4'd0;

   typedef enum logic [1:0] {
      ROW0 = 2'd0,
      ROW1 = 2'd1,
      ROW2 = 2'd2
   } scan_state_t;

   // Key number for a row/column crossing: 1..9, row-major
   function automatic logic [3:0] key_index(input logic [1:0] row, input logic [1:0] col);
      return {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
   endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: key delivery channel from the scanner to the lock FSM.
// valid/ready: the scanner raises key_valid with key_code and holds both stable
// until a rising edge sees key_valid && key_ready; key_ready may stay high.
interface keypad_scanner_if;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_ready;
   logic       key_held;
   logic       overrun;

   modport master (
      output key_code,
      output key_valid,
      output key_held,
      output overrun,
      input  key_ready
   );

   modport slave (
      input  key_code,
      input  key_valid,
      input  key_held,
      input  overrun,
      output key_ready
   );
endinterface

// File: rtl/keypad_scanner_debounce.sv
// keypad_debounce: classifies each full-scan hit image, debounces it over
// DEBOUNCE_SCANS scans and pulses evt_o once per accepted press.
// Optional build macro: KEYPAD_AUTOREPEAT_EN adds a hold counter that re-raises
// the held key every REPEAT_SCANS scans.
module keypad_debounce
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_SCANS = 3,
   parameter int REPEAT_SCANS   = 40
) (
   input  logic       hwclk,
   input  logic       rst,
   input  logic       scan_done_i,
   input  logic [8:0] hit_i,
   output logic       evt_o,
   output logic [3:0] evt_code_o,
   output logic       key_held_o
);

   localparam int            CW      = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);

   logic [3:0]    cand;
   logic [3:0]    n_hits;
   logic          ghost;
   logic [3:0]    prev_q, prev_d;
   logic [3:0]    held_q, held_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          press_evt;

   // Classify the scan: single key, no key, or several keys (ghost/chord)
   always_comb begin
      cand   = KEY_NONE;
      n_hits = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            if (hit_i[r*3+c]) begin
               n_hits = n_hits + 4'd1;
               cand   = key_index(2'(r), 2'(c));
            end
         end
      end
      ghost = (n_hits > 4'd1);
   end

   // Stability count and held-key update at each end of scan
   always_comb begin
      prev_d    = prev_q;
      cnt_d     = cnt_q;
      held_d    = held_q;
      press_evt = 1'b0;
      if (scan_done_i) begin
         if (ghost) begin
            cnt_d = '0;
         end else begin
            prev_d = cand;
            if (cand == prev_q) begin
               cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            end else begin
               cnt_d = CW'(1);
            end
            if (cnt_d == CNT_MAX) begin
               if (cand == KEY_NONE) begin
                  held_d = KEY_NONE;
               end else if (cand != held_q) begin
                  held_d    = cand;
                  press_evt = 1'b1;
               end
            end
         end
      end
   end

   // Debounce state registers
   always_ff @(posedge hwclk or posedge rst) begin
      if (rst) begin
         prev_q <= KEY_NONE;
         held_q <= KEY_NONE;
         cnt_q  <= '0;
      end else begin
         prev_q <= prev_d;
         held_q <= held_d;
         cnt_q  <= cnt_d;
      end
   end

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int            HW       = $clog2(REPEAT_SCANS + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(REPEAT_SCANS);

   logic [HW-1:0] hold_q, hold_d;
   logic          rep_evt;

   // Count scans of continuous hold; repeat the held key every REPEAT_SCANS
   always_comb begin
      hold_d  = hold_q;
      rep_evt = 1'b0;
      if (scan_done_i && !ghost) begin
         if (held_q != KEY_NONE && cand == held_q) begin
            if (hold_q + 1'b1 == HOLD_MAX) begin
               hold_d  = '0;
               rep_evt = 1'b1;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end else begin
            hold_d = '0;
         end
      end
   end

   // Hold counter register
   always_ff @(posedge hwclk or posedge rst) begin
      if (rst) hold_q <= '0;
      else     hold_q <= hold_d;
   end

   assign evt_o = press_evt | rep_evt;
`else
   logic repeat_unused;
   assign repeat_unused = |REPEAT_SCANS;
   assign evt_o         = press_evt;
`endif

   assign evt_code_o = held_d;
   assign key_held_o = (held_q != KEY_NONE);

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: drives the active-low rows, samples the synchronized columns
// once per row, and hands debounced key codes out over a valid/ready register.
// Optional build macro: KEYPAD_AUTOREPEAT_EN (autorepeat, inside keypad_debounce).
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int ROW_PERIOD     = 130000,
   parameter int SETTLE_CYCLES  = 64,
   parameter int DEBOUNCE_SCANS = 3,
   parameter int REPEAT_SCANS   = 40
) (
   input  logic                    hwclk,
   input  logic                    rst,
   output logic                    keypad_r1,
   output logic                    keypad_r2,
   output logic                    keypad_r3,
   input  logic                    keypad_c1,
   input  logic                    keypad_c2,
   input  logic                    keypad_c3,
   keypad_scanner_if.master        key_if,
   output scan_state_t             dbg_state_o
);

   localparam int            TW           = $clog2(ROW_PERIOD);
   localparam logic [TW-1:0] TIMER_LAST   = TW'(ROW_PERIOD - 1);
   localparam logic [TW-1:0] TIMER_SAMPLE = TW'(SETTLE_CYCLES);

   scan_state_t   state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    rows_q, rows_d;
   logic [2:0]    col_meta_q, col_sync_q;
   logic [8:0]    hit_q, hit_d;
   logic          row_end, sample_en, scan_done;
   logic          evt;
   logic [3:0]    evt_code;
   logic          key_held;
   logic [3:0]    code_q, code_d;
   logic          valid_q, valid_d;
   logic          overrun_q, overrun_d;
   logic          accept;

   // Row FSM state and row timer
   always_ff @(posedge hwclk or posedge rst) begin
      if (rst) begin
         state_q <= ROW0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
      end
   end

   // Next row: the timer only wraps through a state advance
   always_comb begin
      row_end = (timer_q == TIMER_LAST);
      timer_d = row_end ? '0 : timer_q + 1'b1;
      state_d = state_q;
      if (row_end) begin
         case (state_q)
            ROW0:    state_d = ROW1;
            ROW1:    state_d = ROW2;
            default: state_d = ROW0;
         endcase
      end
   end

   // FSM outputs: next row pattern, column sample strobe, end-of-scan strobe
   always_comb begin
      case (state_d)
         ROW0:    rows_d = ROW_PAT0;
         ROW1:    rows_d = ROW_PAT1;
         default: rows_d = ROW_PAT2;
      endcase
      sample_en = (timer_q == TIMER_SAMPLE);
      scan_done = (state_q == ROW2) && row_end;
   end

   // Registered row drives: all rows idle high while in reset
   always_ff @(posedge hwclk or posedge rst) begin
      if (rst) rows_q <= 3'b111;
      else     rows_q <= rows_d;
   end

   // Two-flop synchronizer for the asynchronous column lines
   always_ff @(posedge hwclk or posedge rst) begin
      if (rst) begin
         col_meta_q <= 3'b111;
         col_sync_q <= 3'b111;
      end else begin
         col_meta_q <= {keypad_c3, keypad_c2, keypad_c1};
         col_sync_q <= col_meta_q;
      end
   end

   // Hit vector: one 3-bit slice per row, cleared as ROW0 begins
   always_comb begin
      hit_d = hit_q;
      if (scan_done) begin
         hit_d = '0;
      end else if (sample_en) begin
         case (state_q)
            ROW0:    hit_d[2:0] = ~col_sync_q;
            ROW1:    hit_d[5:3] = ~col_sync_q;
            default: hit_d[8:6] = ~col_sync_q;
         endcase
      end
   end

   // Hit vector register
   always_ff @(posedge hwclk or posedge rst) begin
      if (rst) hit_q <= '0;
      else     hit_q <= hit_d;
   end

   keypad_debounce #(
      .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
      .REPEAT_SCANS   (REPEAT_SCANS)
   ) u_debounce (
      .hwclk       (hwclk),
      .rst         (rst),
      .scan_done_i (scan_done),
      .hit_i       (hit_q),
      .evt_o       (evt),
      .evt_code_o  (evt_code),
      .key_held_o  (key_held)
   );

   // Output slot: load on event if free or draining this cycle, else flag overrun
   always_comb begin
      accept    = valid_q && key_if.key_ready;
      code_d    = code_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      if (accept) begin
         valid_d   = 1'b0;
         overrun_d = 1'b0;
      end
      if (evt) begin
         if (!valid_q || key_if.key_ready) begin
            code_d  = evt_code;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   // Output slot registers
   always_ff @(posedge hwclk or posedge rst) begin
      if (rst) begin
         code_q    <= KEY_NONE;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         code_q    <= code_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign {keypad_r3, keypad_r2, keypad_r1} = rows_q;
   assign key_if.key_code  = code_q;
   assign key_if.key_valid = valid_q;
   assign key_if.key_held  = key_held;
   assign key_if.overrun   = overrun_q;
   assign dbg_state_o      = state_q;

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scan controller for the 3×3 door-lock keypad. It sequences the active-low row drives and samples the column lines once per row. It debounces the per-scan key image and delivers one key code per press to the lock FSM over a valid/ready handshake. It replaces free-running row toggling and per-column edge-clocked logic with a single synchronous block on `hwclk`.

## Interface
- `ROW_PERIOD`, 130000: `hwclk` cycles each row is driven; must be > `SETTLE_CYCLES` + 1
- `SETTLE_CYCLES`, 64: cycles after row switch before the columns are sampled
- `DEBOUNCE_SCANS`, 3: consecutive identical full scans needed to accept a press or a release; ≥ 1
- `REPEAT_SCANS`, 40: scans of continuous hold between repeat events; used only with `KEYPAD_AUTOREPEAT_EN`
- `hwclk` in 1: system clock (12 MHz)
- `rst` in 1: reset, asynchronous, active-high
- `keypad_r1`, `keypad_r2`, `keypad_r3` out 1 each: row drives, active-low, at most one low at a time
- `keypad_c1`, `keypad_c2`, `keypad_c3` in 1 each: column sense, active-low, external pull-ups; asynchronous
- `key_code` out 4: accepted key, 1..9; 0 means none
- `key_valid` out 1: `key_code` is valid
- `key_ready` in 1: consumer accepts when `key_valid && key_ready`
- `key_held` out 1: a debounced key is currently down
- `overrun` out 1: sticky; a press event was lost because the output was still occupied

## Operation
- Columns pass through a 2-flop synchronizer before use.
- Scan FSM states: ROW0 → ROW1 → ROW2 → ROW0.
  - Row pattern `{r3,r2,r1}`: ROW0=110, ROW1=101, ROW2=011.
  - Row timer counts 0..`ROW_PERIOD`-1, then advances to the next state and resets to 0.
- At timer == `SETTLE_CYCLES`, the inverted synchronized columns are written into a 9-bit hit vector at bits `row*3+col`.
  - Hit vector clears at the start of ROW0.
- End of scan is ROW2 with timer == `ROW_PERIOD`-1. The scan is classified as:
  - exactly one bit set: candidate = `row*3+col+1`
  - no bits set: candidate = 0
  - more than one bit set (ghost or chord): scan discarded; stability count resets to 0; held state unchanged
- Debounce:
  - If the candidate equals the previous scan's candidate, the stability count increments, saturating at `DEBOUNCE_SCANS`. Otherwise it resets to 1.
  - When the count reaches `DEBOUNCE_SCANS` with a nonzero candidate that differs from the held key:
    - held key ← candidate
    - `key_held` ← 1
    - one press event is raised
  - When the count reaches `DEBOUNCE_SCANS` with candidate 0: held key ← 0, `key_held` ← 0. No event.
  - A direct change from one key to another without a stable zero still raises an event for the new key.
- Output register:
  - On a press event with `key_valid`=0 or a same-cycle accept: load `key_code` and set `key_valid`.
  - On a press event while `key_valid && !key_ready`: the event is dropped, `key_code` is unchanged, and `overrun` ← 1.
  - `overrun` clears on the next successful handshake.
  - `key_valid` clears on accept unless a new event loads in the same cycle.

## Timing
- Reset values: rows 111, `key_code`=0, `key_valid`=0, `key_held`=0, `overrun`=0; FSM=ROW0, timer=0, stability count=0.
- On the first cycle after reset deasserts, the rows become 110.
- Reset asserted mid-scan aborts the scan immediately; the partial hit vector is discarded.
- One scan takes 3·`ROW_PERIOD` cycles.
- Column-to-sample path: 2 synchronizer cycles, then capture at timer == `SETTLE_CYCLES`.
- `key_valid` rises the cycle after the end-of-scan in which the stability count reaches `DEBOUNCE_SCANS`.
- Minimum press-to-valid latency: `DEBOUNCE_SCANS` full scans.
- Handshake: `key_code` is stable while `key_valid && !key_ready`. `key_ready` may be held high permanently.
- Counter widths are `$clog2` of the parameter values; timer wraps only through the state advance.

## Configuration
- `KEYPAD_AUTOREPEAT_EN` defined:
  - While `key_held`=1 and the candidate still equals the held key, a hold counter counts scans.
  - Each time it reaches `REPEAT_SCANS`, the counter resets and a press event for the held key is raised. Overrun rules apply.
  - The hold counter clears on release or on a change of key.
- Not defined: exactly one event per debounced press; no hold counter is synthesized.

## Structure
- Package `keypad_pkg`:
  - `ROW_PAT0/1/2` = 3'b110 / 3'b101 / 3'b011
  - `KEY_NONE` = 4'd0
  - scan-state enum `scan_state_t`
  - function `key_index(row, col)` returning `row*3+col+1`
- Sub-module `keypad_debounce` holds the candidate classification, stability counter, held key, autorepeat and event pulse.
- `keypad_scanner` holds the row FSM, synchronizer, hit vector and output handshake register.

## Test plan
Parameters for all scenarios: `ROW_PERIOD`=16, `SETTLE_CYCLES`=4, `DEBOUNCE_SCANS`=3, `REPEAT_SCANS`=4.
1. Reset, no keys → rows cycle 110/101/011 every 16 cycles; `key_valid` stays 0 for 20 scans.
2. Key row1/col2 held low stable for 4 scans, `key_ready`=1 → exactly one `key_valid` pulse with `key_code`=6, 3 scans after press onset; `key_held`=1 until 3 clean scans after release.
3. Key 1 bounces (present/absent alternating per scan) for 5 scans, then stable → no event during bounce; single `key_code`=1 after 3 stable scans.
4. Keys 2 and 5 pressed together → no event, `key_held` unchanged; releasing key 5 → `key_code`=2 after 3 scans.
5. `key_ready`=0, press 3, release, press 7 → `key_code` stays 3, `overrun`=1; assert `key_ready` → accept 3, `overrun` clears, `key_valid` drops.
6. With `KEYPAD_AUTOREPEAT_EN`, hold 9 for 16 scans, `key_ready`=1 → events at debounce completion and every 4 scans after; reset asserted mid-row → all outputs return to reset values immediately.
